// File: rtl/bloom_filter_unit.sv
// ============================================================================
// Module   : bloom_filter_unit
// Brief    : Bloom-filter responder for custom INSERT/CHECK/CLEAR ops.
//            Optional saturating stats counters under `BLOOM_STATS_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module bloom_filter_unit #(
  parameter int M_BITS = 256,
  parameter int K_HASH = 3,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [1:0]        req_op_i,
  input  logic [DATA_W-1:0] req_data_i,
  output logic              resp_valid_o,
  output logic              resp_match_o,
  output logic              busy_o,
  output logic [15:0]       stat_ins_o,
  output logic [15:0]       stat_hit_o
);

  localparam int IDX_W  = $clog2(M_BITS);
  localparam int NWORDS = M_BITS / 32;
  localparam int WCNT_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;

  localparam logic [31:0]       C_GOLDEN = 32'h9E3779B1;
  localparam logic [3:0][31:0]  C_SEEDS  = {32'h1B873593, 32'hCC9E2D51,
                                            32'h5BD1E995, 32'h00000000};
  localparam logic [1:0] C_OP_NOP    = 2'b00;
  localparam logic [1:0] C_OP_INSERT = 2'b01;
  localparam logic [1:0] C_OP_CHECK  = 2'b10;
  localparam logic [1:0] C_OP_CLEAR  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOOKUP = 2'd1,
    S_CLEAR  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [M_BITS-1:0]   r_array;
  logic [1:0]          r_op;
  logic [DATA_W-1:0]   r_data;
  logic [WCNT_W-1:0]   r_wcnt;
  logic                r_resp_valid;
  logic                r_resp_match;

  logic                w_accept;
  logic                w_last_word;
  logic [31:0]         w_key;
  logic [K_HASH-1:0][IDX_W-1:0] w_idx;
  logic [K_HASH-1:0]   w_hit;
  logic                w_match;

  assign w_accept    = req_valid_i && (r_state == S_IDLE);
  assign w_last_word = (r_wcnt == WCNT_W'(NWORDS - 1));

  generate
    if (DATA_W >= 32) begin : g_key_trunc
      assign w_key = r_data[31:0];
    end else begin : g_key_ext
      assign w_key = {{(32-DATA_W){1'b0}}, r_data};
    end
  endgenerate

  // Multiplicative hash: top IDX_W bits of the 32-bit product index the array.
  generate
    for (genvar gi = 0; gi < K_HASH; gi++) begin : g_hash
      logic [31:0] w_prod;
      assign w_prod     = (w_key ^ C_SEEDS[gi]) * C_GOLDEN;
      assign w_idx[gi]  = w_prod[31 -: IDX_W];
      assign w_hit[gi]  = r_array[w_idx[gi]];
    end
  endgenerate

  assign w_match = &w_hit;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_next = (req_op_i == C_OP_CLEAR) ? S_CLEAR : S_LOOKUP;
      end
      S_LOOKUP: w_next = S_IDLE;
      S_CLEAR:  if (w_last_word) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_array      <= '0;
      r_op         <= C_OP_NOP;
      r_data       <= '0;
      r_wcnt       <= '0;
      r_resp_valid <= 1'b0;
      r_resp_match <= 1'b0;
    end else begin
      r_resp_valid <= 1'b0;
      if (w_accept) begin
        r_op   <= req_op_i;
        r_data <= req_data_i;
        r_wcnt <= '0;
      end
      case (r_state)
        S_LOOKUP: begin
          r_resp_valid <= 1'b1;
          r_resp_match <= ((r_op == C_OP_INSERT) || (r_op == C_OP_CHECK)) ? w_match : 1'b0;
          if (r_op == C_OP_INSERT) begin
            for (int k = 0; k < K_HASH; k++) r_array[w_idx[k]] <= 1'b1;
          end
        end
        S_CLEAR: begin
          r_array[{r_wcnt, 5'b00000} +: 32] <= 32'h0;
          r_wcnt <= r_wcnt + 1'b1;
          if (w_last_word) begin
            r_resp_valid <= 1'b1;
            r_resp_match <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef BLOOM_STATS_EN
  logic [15:0] r_stat_ins;
  logic [15:0] r_stat_hit;

  always_ff @(posedge clk) begin
    if (rst || (w_accept && (req_op_i == C_OP_CLEAR))) begin
      r_stat_ins <= 16'h0;
      r_stat_hit <= 16'h0;
    end else if (r_state == S_LOOKUP) begin
      if ((r_op == C_OP_INSERT) && (r_stat_ins != 16'hFFFF))
        r_stat_ins <= r_stat_ins + 16'h1;
      if ((r_op == C_OP_CHECK) && w_match && (r_stat_hit != 16'hFFFF))
        r_stat_hit <= r_stat_hit + 16'h1;
    end
  end

  assign stat_ins_o = r_stat_ins;
  assign stat_hit_o = r_stat_hit;
`else
  assign stat_ins_o = 16'h0;
  assign stat_hit_o = 16'h0;
`endif

  assign req_ready_o  = (r_state == S_IDLE);
  assign busy_o       = (r_state != S_IDLE);
  assign resp_valid_o = r_resp_valid;
  assign resp_match_o = r_resp_match;

endmodule

`default_nettype wire

// File: tb/tb_bloom_filter_unit.sv
// ============================================================================
// Module   : tb_bloom_filter_unit
// Brief    : Scoreboard bench for bloom_filter_unit with a set-membership model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_bloom_filter_unit;

  localparam int M_BITS = 256;
  localparam int K_HASH = 3;
  localparam int DATA_W = 32;
  localparam int IDX_W  = 8;
  localparam int NW     = M_BITS / 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic [1:0]  req_op = 2'b00;
  logic [31:0] req_data = 32'h0;
  logic        req_ready_o, resp_valid_o, resp_match_o, busy_o;
  logic [15:0] stat_ins_o, stat_hit_o;

  bloom_filter_unit #(.M_BITS(M_BITS), .K_HASH(K_HASH), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready_o),
    .req_op_i(req_op), .req_data_i(req_data),
    .resp_valid_o(resp_valid_o), .resp_match_o(resp_match_o),
    .busy_o(busy_o), .stat_ins_o(stat_ins_o), .stat_hit_o(stat_hit_o)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct { bit m; int unsigned at; } exp_t;
  exp_t q[$];

  bit          mdl[M_BITS];
  int unsigned free_at = 0;
  bit          last_m = 1'b0;
  int unsigned m_ins = 0, m_hit = 0;
  bit [31:0]   seeds[4] = '{32'h00000000, 32'h5BD1E995, 32'hCC9E2D51, 32'h1B873593};

  function automatic int hidx(bit [31:0] key, int i);
    bit [31:0] p;
    p = (key ^ seeds[i]) * 32'h9E3779B1;
    return int'(p >> (32 - IDX_W));
  endfunction

  task automatic chk(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Accept observer: predicts ready/busy and pushes the expected response.
  always @(negedge clk) begin
    bit er, m, rm;
    if (!rst) begin
      er = (cyc >= free_at);
      chk("ready", req_ready_o, er);
      chk("busy", busy_o, !er);
      if (req_valid && er) begin
        if (req_op == 2'b11) begin
          foreach (mdl[i]) mdl[i] = 1'b0;
          m_ins = 0; m_hit = 0;
          q.push_back('{1'b0, cyc + 1 + NW});
          free_at = cyc + 1 + NW;
        end else begin
          m = 1'b1;
          for (int k = 0; k < K_HASH; k++) if (!mdl[hidx(req_data, k)]) m = 1'b0;
          if (req_op == 2'b01) begin
            for (int k = 0; k < K_HASH; k++) mdl[hidx(req_data, k)] = 1'b1;
            if (m_ins < 16'hFFFF) m_ins++;
          end
          if (req_op == 2'b10 && m && m_hit < 16'hFFFF) m_hit++;
          rm = (req_op == 2'b00) ? 1'b0 : m;
          q.push_back('{rm, cyc + 2});
          free_at = cyc + 2;
        end
      end
    end
  end

  // Response monitor.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (q.size() > 0 && q[0].at < cyc) begin
        chk("resp_missing", 0, 1);
        e = q.pop_front();
      end
      if (resp_valid_o) begin
        if (q.size() == 0) chk("resp_unexpected", 1, 0);
        else begin
          e = q.pop_front();
          chk("resp_cycle", cyc, e.at);
          chk("resp_match", resp_match_o, e.m);
          last_m = e.m;
        end
      end else begin
        chk("match_hold", resp_match_o, last_m);
      end
    end
  end

  task automatic do_reset(int n);
    rst = 1'b1;
    req_valid = 1'b0;
    q.delete();
    foreach (mdl[i]) mdl[i] = 1'b0;
    free_at = 0; last_m = 1'b0; m_ins = 0; m_hit = 0;
    repeat (n) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic send(logic [1:0] op, logic [31:0] data, bit hold = 1'b0);
    bit ok;
    int n;
    ok = 1'b0; n = 0;
    req_valid = 1'b1; req_op = op; req_data = data;
    while (!ok && n < 100) begin
      @(negedge clk); ok = req_ready_o;
      @(posedge clk); #1;
      n++;
    end
    if (!ok) chk("accept_timeout", 0, 1);
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((q.size() != 0 || !req_ready_o) && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 200) chk("idle_timeout", 0, 1);
  endtask

  task automatic check_stats(string tag);
`ifdef BLOOM_STATS_EN
    chk({tag, "_stat_ins"}, stat_ins_o, m_ins);
    chk({tag, "_stat_hit"}, stat_hit_o, m_hit);
`else
    chk({tag, "_stat_ins"}, stat_ins_o, 0);
    chk({tag, "_stat_hit"}, stat_hit_o, 0);
`endif
  endtask

  initial begin
    do_reset(3);
    chk("rst_resp_valid", resp_valid_o, 0);
    chk("rst_resp_match", resp_match_o, 0);
    chk("rst_ready", req_ready_o, 1);
    chk("rst_busy", busy_o, 0);
    check_stats("rst");

    // 1: first CHECK on empty filter
    send(2'b10, 32'hDEADBEEF);
    chk("ready_drop", req_ready_o, 0);
    wait_idle();

    // 2: insert twice then check
    send(2'b01, 32'hDEADBEEF);
    send(2'b01, 32'hDEADBEEF);
    send(2'b10, 32'hDEADBEEF);
    wait_idle();

    // 3: no false negatives
    do_reset(1);
    for (int i = 1; i <= 16; i++) send(2'b01, 32'(i));
    for (int i = 1; i <= 16; i++) send(2'b10, 32'(i));
    wait_idle();
    check_stats("t3");

    // 4: CLEAR sweep
    send(2'b11, 32'h0);
    wait_idle();
    send(2'b10, 32'hDEADBEEF);
    wait_idle();
    check_stats("t4");

    // 5: reset in the middle of a CLEAR
    for (int i = 0; i < 4; i++) send(2'b01, 32'hA0 + 32'(i));
    wait_idle();
    send(2'b11, 32'h0);
    repeat (3) @(posedge clk);
    #1 do_reset(1);
    chk("t5_ready", req_ready_o, 1);
    chk("t5_resp_valid", resp_valid_o, 0);
    for (int i = 0; i < 4; i++) send(2'b10, 32'hA0 + 32'(i));
    wait_idle();

    // 6: valid held through busy, then NOP leaves array alone
    send(2'b01, 32'h12345678);
    send(2'b11, 32'h0, 1'b1);
    send(2'b10, 32'h12345678);
    send(2'b01, 32'hCAFEF00D);
    send(2'b00, 32'hCAFEF00D);
    send(2'b00, 32'h55AA55AA);
    send(2'b10, 32'hCAFEF00D);
    send(2'b10, 32'h55AA55AA);
    wait_idle();

    // random traffic from a small key pool so hits occur
    for (int it = 0; it < 400; it++) begin
      logic [1:0]  op;
      logic [31:0] key;
      op  = ($urandom_range(0, 99) < 3) ? 2'b11 : 2'($urandom_range(0, 2));
      key = ($urandom_range(0, 3) == 0) ? $urandom : 32'h1000 + 32'($urandom_range(0, 40));
      send(op, key);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    wait_idle();
    check_stats("rand");

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
